p2s_lane_scheduler: RTL and testbench

Shares a single serial output lane between two 8-bit parallel requesters (lane 0, lane 1) at the serializer bit rate.
- After reset, sends a fixed train of idle symbols for link sync, then goes active.
- While active, round-robins full bytes from two one-entry holding buffers onto the lane, MSB first; inserts idle symbols when neither buffer holds data.
- Sits between the parallel byte sources and the physical serial link, in the clk_8f domain.

---
 rtl/p2s_lane_scheduler.sv | 162 ++++++++++++++++
 tb/tb_p2s_lane_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/p2s_lane_scheduler.sv
// Two-lane byte-to-serial scheduler: sync idle train after reset, then MSB-first round-robin of held bytes.
// Optional P2S_BYTE_CNT_EN adds a 16-bit count of transmitted data symbols (byte_cnt).

module p2s_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             active,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             grant,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] hold
);
  assign ready = active && !full;

  // Accept and grant are exclusive: accept needs !full, grant needs full.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      full <= 1'b0;
      hold <= '0;
    end else if (valid && ready) begin
      full <= 1'b1;
      hold <= data;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

module p2s_lane_scheduler #(
  parameter int             WIDTH      = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
  parameter int             SYNC_BYTES = 4
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in0,
  input  logic             valid_in0,
  output logic             ready0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             valid_in1,
  output logic             ready1,
  output logic             data_out,
  output logic             byte_start,
  output logic             data_flag,
  output logic             lane_id,
  output logic             active
`ifdef P2S_BYTE_CNT_EN
  ,
  output logic [15:0]      byte_cnt
`endif
);
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data, hold;
  logic [NUM_LANES-1:0]            lane_valid, ready, full, grant;

  logic [0:0]       state;
  logic [7:0]       sync_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-2:0] shift;
  logic             last_grant;
  logic             load, gnt_vld, gnt_lane;
  logic [WIDTH-1:0] next_sym;

  assign lane_data  = {data_in1, data_in0};
  assign lane_valid = {valid_in1, valid_in0};
  assign ready0     = ready[0];
  assign ready1     = ready[1];
  assign active     = (state == ST_ACTIVE);
  assign load       = (bit_cnt == LAST);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    p2s_hold_buf #(.WIDTH(WIDTH)) u_buf (
      .clk_8f  (clk_8f),
      .reset_L (reset_L),
      .active  (active),
      .valid   (lane_valid[g]),
      .data    (lane_data[g]),
      .grant   (grant[g]),
      .ready   (ready[g]),
      .full    (full[g]),
      .hold    (hold[g])
    );
  end

  // Round-robin only matters when both hold data; otherwise the full one wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = 1'b0;
    if (state == ST_ACTIVE) begin
      if (&full) begin
        gnt_vld  = 1'b1;
        gnt_lane = ~last_grant;
      end else if (full[0]) begin
        gnt_vld  = 1'b1;
        gnt_lane = 1'b0;
      end else if (full[1]) begin
        gnt_vld  = 1'b1;
        gnt_lane = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && gnt_vld) grant[gnt_lane] = 1'b1;
  end

  assign next_sym = gnt_vld ? hold[gnt_lane] : IDLE_SYM;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ST_SYNC;
      sync_cnt   <= 8'(SYNC_BYTES);
      bit_cnt    <= LAST;
      shift      <= '0;
      data_out   <= 1'b0;
      byte_start <= 1'b0;
      data_flag  <= 1'b0;
      lane_id    <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      shift      <= next_sym[WIDTH-2:0];
      data_out   <= next_sym[WIDTH-1];
      byte_start <= 1'b1;
      bit_cnt    <= '0;
      data_flag  <= gnt_vld;
      if (gnt_vld) begin
        lane_id    <= gnt_lane;
        last_grant <= gnt_lane;
      end
      // The symbol loaded on the entry edge is still idle: no buffer could fill during sync.
      if (state == ST_SYNC) begin
        if (sync_cnt == 8'd0) state <= ST_ACTIVE;
        else                  sync_cnt <= sync_cnt - 8'd1;
      end
    end else begin
      shift      <= {shift[WIDTH-3:0], 1'b0};
      data_out   <= shift[WIDTH-2];
      byte_start <= 1'b0;
      bit_cnt    <= bit_cnt + CNT_W'(1);
    end
  end

`ifdef P2S_BYTE_CNT_EN
  logic [15:0] byte_cnt_r;
  assign byte_cnt = byte_cnt_r;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L)              byte_cnt_r <= '0;
    else if (load && gnt_vld)  byte_cnt_r <= byte_cnt_r + 16'd1;
  end
`endif
endmodule

// File: tb/tb_p2s_lane_scheduler.sv
// Directed bench for p2s_lane_scheduler: symbol-level vector table plus hand sequences for ready, reset and byte_cnt.

module tb_p2s_lane_scheduler;
  logic       clk_8f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in0 = '0, data_in1 = '0;
  logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
  logic       ready0, ready1, data_out, byte_start, data_flag, lane_id, active;
`ifdef P2S_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  always #5 clk_8f = ~clk_8f;

  p2s_lane_scheduler dut (
    .clk_8f     (clk_8f),
    .reset_L    (reset_L),
    .data_in0   (data_in0),
    .valid_in0  (valid_in0),
    .ready0     (ready0),
    .data_in1   (data_in1),
    .valid_in1  (valid_in1),
    .ready1     (ready1),
    .data_out   (data_out),
    .byte_start (byte_start),
    .data_flag  (data_flag),
    .lane_id    (lane_id),
    .active     (active)
`ifdef P2S_BYTE_CNT_EN
    ,
    .byte_cnt   (byte_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] sym;
    logic       flag;
    logic       lane;
    logic       stable;
  } sym_t;
  sym_t sym_q[$];

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [7:0] esym;
    logic       eflag;
    logic       elane;
  } vec_t;
  localparam int NV = 10;
  vec_t tbl[NV];

  // Reassemble serial symbols, MSB first, tagging flag/lane and whether they held steady.
  logic [7:0] m_sym;
  int         m_cnt = 0;
  logic       m_flag, m_lane, m_stable;
  initial forever begin
    @(negedge clk_8f);
    if (!reset_L) m_cnt = 0;
    else if (byte_start) begin
      m_sym = {7'b0, data_out}; m_flag = data_flag; m_lane = lane_id;
      m_stable = 1'b1; m_cnt = 1;
    end else if (m_cnt > 0 && m_cnt < 8) begin
      m_sym = {m_sym[6:0], data_out}; m_cnt++;
      if (data_flag !== m_flag || lane_id !== m_lane) m_stable = 1'b0;
    end
    if (m_cnt == 8) begin
      sym_q.push_back('{m_sym, m_flag, m_lane, m_stable});
      m_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_sym(input string name, input int idx, input logic [7:0] esym,
                         input logic eflag, input logic elane);
    if (idx >= sym_q.size()) begin
      checks++; errors++;
      $display("FAIL %s: symbol %0d never completed", name, idx);
    end else
      chk(name, {sym_q[idx].sym, sym_q[idx].flag, sym_q[idx].lane, sym_q[idx].stable},
          {esym, eflag, elane, 1'b1});
  endtask

  task automatic wait_load(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk_8f); #1;
      seen = byte_start;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no load edge within 20 cycles got 0 expected 1", name);
    end
  endtask

  initial begin
    int bs_bad, fl_bad, rd_bad, base, idx5a;
    logic seen;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'hBC, 8'hBC, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h11, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h22, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h11, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h11, 1'b1, 8'h22, 8'h22, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'hBC, 1'b0, 1'b0};

    repeat (3) @(posedge clk_8f);
    #1;
    chk("reset_outputs", {data_out, byte_start, data_flag, lane_id, active, ready0, ready1}, 0);
`ifdef P2S_BYTE_CNT_EN
    chk("byte_cnt_reset", byte_cnt, 0);
`endif
    @(negedge clk_8f); #2 reset_L = 1'b1;

    // Sync train: load every 8th edge starting at edge 1, active on edge 33.
    bs_bad = 0; fl_bad = 0;
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk_8f); #1;
      if (byte_start !== ((e % 8) == 1)) bs_bad++;
      if (data_flag !== 1'b0) fl_bad++;
      if (e == 32) chk("active_before_edge33", active, 0);
    end
    chk("active_at_edge33", active, 1);
    chk("ready0_after_active", ready0, 1);
    chk("byte_start_cadence", bs_bad, 0);
    chk("sync_flag_low", fl_bad, 0);

    wait_load("table_start");
    base = sym_q.size();
    for (int i = 0; i < NV; i++) begin
      if (i > 0) wait_load($sformatf("table_load%0d", i));
`ifdef P2S_BYTE_CNT_EN
      if (i == 5) chk("byte_cnt_after_3_data", byte_cnt, 3);
`endif
      valid_in0 = tbl[i].v0; data_in0 = tbl[i].d0;
      valid_in1 = tbl[i].v1; data_in1 = tbl[i].d1;
    end
    wait_load("table_drain");
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    wait_load("table_end");

    for (int k = 0; k < 5; k++) chk_sym($sformatf("sync_sym%0d", k), k, 8'hBC, 1'b0, 1'b0);
    for (int i = 0; i < NV; i++)
      chk_sym($sformatf("table_sym%0d", i), base + i + 1, tbl[i].esym, tbl[i].eflag, tbl[i].elane);

    // ready0 stays low from accept until the load edge that grants the byte.
    valid_in0 = 1'b1; data_in0 = 8'h5A;
    @(posedge clk_8f); #1;
    chk("ready0_low_after_accept", ready0, 0);
    valid_in0 = 1'b0;
`ifdef P2S_BYTE_CNT_EN
    force dut.byte_cnt_r = 16'hFFFF;
    #1 release dut.byte_cnt_r;
`endif
    rd_bad = 0; seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk_8f); #1;
      seen = byte_start;
      if (!seen && ready0 !== 1'b0) rd_bad++;
    end
    chk("load_edge_seen", seen, 1);
    chk("ready0_low_while_full", rd_bad, 0);
    chk("ready0_high_after_load", ready0, 1);
`ifdef P2S_BYTE_CNT_EN
    chk("byte_cnt_wrap", byte_cnt, 0);
`endif
    idx5a = sym_q.size();
    wait_load("after_5a");
    chk_sym("sym_5a", idx5a, 8'h5A, 1'b1, 1'b0);

    // Lane 1 byte on the wire, lane 0 buffer full, then reset at bit 3.
    valid_in1 = 1'b1; data_in1 = 8'h77;
    wait_load("load_77");
    valid_in1 = 1'b0;
    valid_in0 = 1'b1; data_in0 = 8'h66;
    repeat (3) @(posedge clk_8f);
    #1;
    chk("pre_reset_state", {data_flag, lane_id, ready0}, 3'b110);
    #2 reset_L = 1'b0; valid_in0 = 1'b0;
    #1;
    chk("reset_async", {data_out, byte_start, data_flag, lane_id, active, ready0, ready1}, 0);
    repeat (2) @(negedge clk_8f);
    sym_q.delete();
    #2 reset_L = 1'b1;
    for (int n = 0; n < 70 && sym_q.size() < 6; n++) @(posedge clk_8f);
    #1;
    for (int k = 0; k < 6; k++) chk_sym($sformatf("post_reset_sym%0d", k), k, 8'hBC, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
